// File: rtl/rom_read_arbiter.sv
// Two-requester burst read arbiter in front of a synchronous 4K x 32 ROM.
// Define ROM_ARB_RR_EN for round-robin arbitration; default is fixed priority (requester 0).
module rom_read_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_0,
    input  logic [31:0] addr_0,
    input  logic [3:0]  len_0,
    output logic        gnt_0,
    input  logic        req_1,
    input  logic [31:0] addr_1,
    input  logic [3:0]  len_1,
    output logic        gnt_1,
    output logic        rvalid_0,
    output logic [31:0] rdata_0,
    output logic        rlast_0,
    input  logic        rready_0,
    output logic        rvalid_1,
    output logic [31:0] rdata_1,
    output logic        rlast_1,
    input  logic        rready_1,
    output logic        ROM_en,
    output logic        ROM_read,
    output logic [11:0] ROM_addr,
    input  logic [31:0] ROM_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        owner_r;
    logic        owner_s;
    logic [11:0] base_r;
    logic [11:0] base_s;
    logic [3:0]  len_r;
    logic [3:0]  len_s;
    logic [3:0]  beat_cnt_r;
    logic [3:0]  beat_cnt_s;
    logic        win_s;
    logic        grant_s;
    logic        own_rready_s;
    logic        last_s;
    logic [11:0] cur_addr_s;
    logic        unused_s;

    // Only the word-address bits [13:2] reach the ROM.
    assign unused_s     = ^{addr_0[31:14], addr_0[1:0], addr_1[31:14], addr_1[1:0]};
    assign grant_s      = rst && (state_r == IDLE) && (req_0 || req_1);
    assign own_rready_s = owner_r ? rready_1 : rready_0;
    assign last_s       = (beat_cnt_r == len_r);
    assign cur_addr_s   = base_r + {8'd0, beat_cnt_r};

`ifdef ROM_ARB_RR_EN
    logic last_gnt_r;

    // Round-robin pick: on a tie the requester not granted last wins.
    always_comb begin
        if (req_0 && req_1) begin
            win_s = ~last_gnt_r;
        end else if (req_0) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
    end

    // Last-granted pointer; resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt_r <= 1'b1;
        end else if (grant_s) begin
            last_gnt_r <= win_s;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end
`else
    // Fixed priority: requester 0 always wins a tie.
    always_comb begin
        if (req_0) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
    end
`endif

    // Next-state logic for the FSM and the burst context registers.
    always_comb begin
        state_s    = state_r;
        owner_s    = owner_r;
        base_s     = base_r;
        len_s      = len_r;
        beat_cnt_s = beat_cnt_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    owner_s    = win_s;
                    base_s     = win_s ? addr_1[13:2] : addr_0[13:2];
                    len_s      = win_s ? len_1 : len_0;
                    beat_cnt_s = 4'd0;
                    state_s    = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s = DATA;
            end
            DATA: begin
                // Last handshake returns to IDLE; the grant waits one bubble cycle.
                if (own_rready_s && last_s) begin
                    beat_cnt_s = 4'd0;
                    state_s    = IDLE;
                end else if (own_rready_s) begin
                    beat_cnt_s = beat_cnt_r + 4'd1;
                end else begin
                    beat_cnt_s = beat_cnt_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and burst context registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            owner_r    <= 1'b0;
            base_r     <= 12'd0;
            len_r      <= 4'd0;
            beat_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_s;
            owner_r    <= owner_s;
            base_r     <= base_s;
            len_r      <= len_s;
            beat_cnt_r <= beat_cnt_s;
        end
    end

    // Output decode; the ROM address runs one beat ahead unless the owner stalls.
    always_comb begin
        gnt_0    = 1'b0;
        gnt_1    = 1'b0;
        rvalid_0 = 1'b0;
        rdata_0  = 32'd0;
        rlast_0  = 1'b0;
        rvalid_1 = 1'b0;
        rdata_1  = 32'd0;
        rlast_1  = 1'b0;
        ROM_en   = 1'b0;
        ROM_read = 1'b0;
        ROM_addr = 12'd0;
        busy     = 1'b0;
        if (rst) begin
            case (state_r)
                IDLE: begin
                    gnt_0 = grant_s && !win_s;
                    gnt_1 = grant_s && win_s;
                end
                ISSUE: begin
                    busy     = 1'b1;
                    ROM_en   = 1'b1;
                    ROM_read = 1'b1;
                    ROM_addr = base_r;
                end
                DATA: begin
                    busy     = 1'b1;
                    ROM_en   = 1'b1;
                    ROM_read = 1'b1;
                    ROM_addr = own_rready_s ? (cur_addr_s + 12'd1) : cur_addr_s;
                    if (owner_r) begin
                        rvalid_1 = 1'b1;
                        rdata_1  = ROM_out;
                        rlast_1  = last_s;
                    end else begin
                        rvalid_0 = 1'b1;
                        rdata_0  = ROM_out;
                        rlast_0  = last_s;
                    end
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end else begin
            busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench for rom_read_arbiter: directed bursts push expected beats,
// a negedge monitor pops and compares every delivered beat.
module tb_rom_read_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_0, req_1;
    logic [31:0] addr_0, addr_1;
    logic [3:0]  len_0, len_1;
    logic        gnt_0, gnt_1;
    logic        rvalid_0, rvalid_1;
    logic [31:0] rdata_0, rdata_1;
    logic        rlast_0, rlast_1;
    logic        rready_0, rready_1;
    logic        ROM_en, ROM_read, busy;
    logic [11:0] ROM_addr;
    logic [31:0] ROM_out = 32'd0;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    int    checks = 0;
    int    errors = 0;

    rom_read_arbiter dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .addr_0(addr_0), .len_0(len_0), .gnt_0(gnt_0),
        .req_1(req_1), .addr_1(addr_1), .len_1(len_1), .gnt_1(gnt_1),
        .rvalid_0(rvalid_0), .rdata_0(rdata_0), .rlast_0(rlast_0), .rready_0(rready_0),
        .rvalid_1(rvalid_1), .rdata_1(rdata_1), .rlast_1(rlast_1), .rready_1(rready_1),
        .ROM_en(ROM_en), .ROM_read(ROM_read), .ROM_addr(ROM_addr), .ROM_out(ROM_out),
        .busy(busy)
    );

    // Clock generation.
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [11:0] a);
        return {8'hC3, 4'h0, a, ~a[7:0]};
    endfunction

    // Synchronous ROM model: data appears one cycle after the address.
    always @(posedge clk) begin
        if (ROM_en && ROM_read) ROM_out <= rom_word(ROM_addr);
    end

    function automatic logic [95:0] all_outs();
        return {gnt_0, gnt_1, rvalid_0, rvalid_1, rlast_0, rlast_1, rdata_0, rdata_1,
                ROM_en, ROM_read, ROM_addr, busy};
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int p, input logic [31:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        if (p == 0) q0.push_back(b);
        else q1.push_back(b);
    endtask

    task automatic set_rr(input int p, input logic v);
        if (p == 0) rready_0 = v;
        else rready_1 = v;
    endtask

    // Monitor: pop and compare on every handshake; idle ports must stay zero.
    always @(negedge clk) begin : monitor
        beat_t b;
        if (rvalid_0 && rready_0) begin
            check("beat_expected_0", q0.size() > 0, 1'b1);
            if (q0.size() > 0) begin
                b = q0.pop_front();
                check("rdata_0", rdata_0, b.data);
                check("rlast_0", rlast_0, b.last);
            end
        end else if (!rvalid_0) begin
            check("idle_port_0", {rdata_0, rlast_0}, 96'd0);
        end
        if (rvalid_1 && rready_1) begin
            check("beat_expected_1", q1.size() > 0, 1'b1);
            if (q1.size() > 0) begin
                b = q1.pop_front();
                check("rdata_1", rdata_1, b.data);
                check("rlast_1", rlast_1, b.last);
            end
        end else if (!rvalid_1) begin
            check("idle_port_1", {rdata_1, rlast_1}, 96'd0);
        end
    end

    task automatic run_burst(input int p, input logic [31:0] a, input logic [3:0] l,
                             input int stall_beat, input int stall_n, input int abort_beat);
        logic [11:0] base;
        logic [11:0] ba;
        logic        got;
        logic        rr;
        int          k, s, cyc;
        base = a[13:2];
        for (int i = 0; i <= int'(l); i++) begin
            ba = base + 12'(i);
            push(p, rom_word(ba), i == int'(l));
        end
        @(posedge clk); #1;
        set_rr(p, 1'b1);
        if (p == 0) begin addr_0 = a; len_0 = l; req_0 = 1'b1; end
        else begin addr_1 = a; len_1 = l; req_1 = 1'b1; end
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = (p == 0) ? gnt_0 : gnt_1;
        end
        check("grant", got, 1'b1);
        check("grant_exclusive", (p == 0) ? gnt_1 : gnt_0, 1'b0);
        @(posedge clk); #1;
        req_0 = 1'b0;
        req_1 = 1'b0;
        if (!got) return;
        @(negedge clk);
        check("issue_addr", ROM_addr, base);
        check("issue_ctrl", {busy, ROM_en, ROM_read, rvalid_0, rvalid_1}, 5'b11100);
        k = 0; s = 0; cyc = 0;
        while (k <= int'(l) && cyc < 64) begin
            @(posedge clk); #1;
            if (k == abort_beat) begin
                #1 rst = 1'b0;
                #1 check("reset_midburst_outputs", all_outs(), 96'd0);
                if (p == 0) q0.delete();
                else q1.delete();
                break;
            end
            rr = !(k == stall_beat && s < stall_n);
            set_rr(p, rr);
            @(negedge clk);
            check("beat_valid", {((p == 0) ? rvalid_0 : rvalid_1), busy}, 2'b11);
            ba = rr ? (base + 12'(k) + 12'd1) : (base + 12'(k));
            check("rom_addr", ROM_addr, ba);
            if (!rr) begin
                ba = base + 12'(k);
                check("stall_data", (p == 0) ? rdata_0 : rdata_1, rom_word(ba));
                s++;
            end else begin
                k++;
            end
            cyc++;
        end
        set_rr(p, 1'b1);
        if (abort_beat < 0) begin
            @(negedge clk);
            check("burst_end_idle", {busy, ROM_en, ROM_read, ROM_addr, rvalid_0, rvalid_1}, 96'd0);
        end
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        int ng, cyc;
        int order[3];
        int exp_order[3];
`ifdef ROM_ARB_RR_EN
        exp_order = '{0, 1, 0};
`else
        exp_order = '{0, 0, 0};
`endif
        order = '{-1, -1, -1};
        rst = 1'b0;
        req_0 = 1'b0; req_1 = 1'b0;
        addr_0 = 32'd0; addr_1 = 32'd0;
        len_0 = 4'd0; len_1 = 4'd0;
        rready_0 = 1'b1; rready_1 = 1'b1;
        #2 req_0 = 1'b1; req_1 = 1'b1;
        #1 check("reset_outputs", all_outs(), 96'd0);
        req_0 = 1'b0; req_1 = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("idle_outputs", all_outs(), 96'd0);

        run_burst(0, 32'h0000_0010, 4'd0, -1, 0, -1);
        run_burst(1, 32'h0000_0020, 4'd3, 1, 2, -1);
        run_burst(0, 32'h0000_3FF8, 4'd3, -1, 0, -1);
        run_burst(1, 32'h0000_0040, 4'd7, -1, 0, 2);

        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_quiet", {ROM_en, busy, rvalid_0, rvalid_1}, 96'd0);
        end

        @(posedge clk); #1;
        addr_0 = 32'h0000_0100; len_0 = 4'd0;
        addr_1 = 32'h0000_0200; len_1 = 4'd0;
        req_0 = 1'b1; req_1 = 1'b1;
        ng = 0; cyc = 0;
        while (ng < 3 && cyc < 40) begin
            @(negedge clk);
            if (gnt_0 || gnt_1) begin
                check("gnt_onehot", gnt_0 && gnt_1, 1'b0);
                order[ng] = gnt_1 ? 1 : 0;
                if (gnt_1) push(1, rom_word(12'h080), 1'b1);
                else push(0, rom_word(12'h040), 1'b1);
                ng++;
            end
            cyc++;
        end
        check("contention_grants", ng, 3);
        @(posedge clk); #1;
        req_0 = 1'b0; req_1 = 1'b0;
        for (int i = 0; i < 3; i++) check("grant_order", order[i], exp_order[i]);
        repeat (6) @(posedge clk);
        #1;
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_read_arbiter.md
ROM_READ_ARBITER -- requirements
Module: rom_read_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset. Ports: clk input 1 (rising-edge clock); rst input 1 (asynchronous active-low reset).
REQ-002 The block SHALL provide the following requester ports, where i = 0,1:
- req_i input 1: read request; held high until granted.
- addr_i input 32: byte start address; bits [13:2] are used.
- len_i input 4: burst beats minus 1.
- gnt_i output 1: one-cycle grant pulse.
REQ-003 The block SHALL provide the following return ports, where i = 0,1:
- rvalid_i output 1: read data valid.
- rdata_i output 32: read data.
- rlast_i output 1: final beat of the burst.
- rready_i input 1: requester accepts the beat.
REQ-004 The block SHALL provide the following ROM-side ports:
- ROM_en output 1: ROM chip enable.
- ROM_read output 1: ROM output enable.
- ROM_addr output 12: ROM word address.
- ROM_out input 32: ROM data, valid one cycle after the address is presented.
- busy output 1: a burst is in progress.

Function
REQ-005 The FSM SHALL have three states, IDLE, ISSUE and DATA, with IDLE as the reset state.
REQ-006 In IDLE, when any req_i is high, the block SHALL assert exactly one gnt_i combinationally in that cycle, latch the owner, base = addr_i[13:2] and len = len_i, clear beat_cnt, and move to ISSUE.
REQ-007 In ISSUE, the block SHALL drive ROM_en=1, ROM_read=1 and ROM_addr=base, and SHALL move to DATA on the next cycle.
REQ-008 In DATA, the block SHALL drive rvalid_owner=1, rdata_owner=ROM_out and rlast_owner=(beat_cnt==len).
REQ-009 In DATA, ROM_en and ROM_read SHALL remain 1.
REQ-010 In DATA, ROM_addr SHALL be base+beat_cnt+1 when rready_owner=1, and base+beat_cnt otherwise, so that a stalled beat is re-read and held stable.
REQ-011 A handshake (rvalid&rready) on a non-last beat SHALL increment beat_cnt.
REQ-012 A handshake on the last beat SHALL clear beat_cnt and return the FSM to IDLE. A new grant SHALL NOT be issued in that same cycle, so there is exactly one IDLE bubble between bursts.
REQ-013 First-beat latency SHALL be 2 cycles from gnt, and throughput SHALL be 1 beat/cycle while rready is held high.
REQ-014 ROM_addr arithmetic SHALL be 12-bit modulo 4096: a burst crossing 0xFFF wraps to 0x000 with no error signalled.
REQ-015 A non-owner requester SHALL see rvalid=0, rlast=0 and rdata=0 at all times.
REQ-016 In IDLE, the block SHALL drive ROM_en=0, ROM_read=0 and ROM_addr=0.
REQ-017 busy SHALL be 1 in the ISSUE and DATA states.
REQ-018 Requests arriving outside IDLE SHALL be ignored until IDLE. Requesters SHALL hold req, addr and len stable until gnt.
REQ-019 Arbitration on simultaneous requests SHALL follow REQ-024 and REQ-025.
REQ-020 A req_i falling without a grant SHALL be legal and SHALL be dropped.

Reset
REQ-021 On rst low, the block SHALL immediately clear state to IDLE and clear owner, base, len, beat_cnt and the round-robin pointer (pointer=1, so requester 0 wins first).
REQ-022 During reset, all outputs SHALL be 0.
REQ-023 A reset asserted mid-burst SHALL abort the burst with no further rvalid. After reset release, the next beat SHALL only follow a new grant.

Configuration
REQ-024 With macro ROM_ARB_RR_EN defined, arbitration SHALL be round-robin: on simultaneous requests the requester that was not granted last wins, and the pointer updates on each grant.
REQ-025 Without ROM_ARB_RR_EN, arbitration SHALL be fixed priority, with requester 0 always winning on simultaneous requests, and the pointer logic absent.

Verification
REQ-026 Single beat: req_0=1, addr_0=0x0000_0010, len_0=0 -> gnt_0 at cycle T; ROM_addr=0x004 at T+1; at T+2 rvalid_0=1, rlast_0=1, rdata_0=ROM[4]; IDLE at T+3.
REQ-027 Burst with stall: addr_1=0x20, len_1=3, rready_1 low on beat 1 for 2 cycles -> ROM_addr holds 0x009 and rdata_1 is stable during the stall; beats ROM[8..11] are delivered in order and rlast_1 is asserted only on ROM[11].
REQ-028 Wrap: addr_0=0x3FF8, len_0=3 -> ROM_addr sequence 0xFFE, 0xFFF, 0x000, 0x001; rlast_0 is asserted on the 4th beat.
REQ-029 Contention: req_0 and req_1 both held high for 3 bursts -> with ROM_ARB_RR_EN the grant order is 0, 1, 0; without the macro it is 0, 0, 0 and req_1 is starved.
REQ-030 Reset mid-burst: rst low during beat 2 of a len=7 burst -> all outputs are 0 within the same cycle; after release with no req, ROM_en stays 0 and no rvalid is asserted.
